// File: rtl/parking_lot_ctrl_if.sv
// Gate-side bundle for the parking-lot controller: hour, entry/exit requests,
// occupancy readouts, verdict pulses and FSM debug state.
interface parking_lot_ctrl_if #(
  parameter int W = 10
);
  logic [4:0]   hour;
  logic         ent_valid;
  logic         ent_ready;
  logic         ent_uni;
  logic         ext_valid;
  logic         ext_ready;
  logic         ext_uni;
  logic [W-1:0] uni_cnt;
  logic [W-1:0] pub_cnt;
  logic [W-1:0] mig_cnt;
  logic [W-1:0] uni_free;
  logic [W-1:0] pub_free;
  logic         uni_avail;
  logic         pub_avail;
  logic         ent_ok;
  logic         ent_to_pub;
  logic         ent_deny;
  logic         ext_err;
  logic         busy;
  logic         dbg_state;

  modport master (
    output hour, ent_valid, ent_uni, ext_valid, ext_uni,
    input  ent_ready, ext_ready, uni_cnt, pub_cnt, mig_cnt, uni_free, pub_free,
           uni_avail, pub_avail, ent_ok, ent_to_pub, ent_deny, ext_err, busy, dbg_state
  );

  modport slave (
    input  hour, ent_valid, ent_uni, ext_valid, ext_uni,
    output ent_ready, ext_ready, uni_cnt, pub_cnt, mig_cnt, uni_free, pub_free,
           uni_avail, pub_avail, ent_ok, ent_to_pub, ent_deny, ext_err, busy, dbg_state
  );
endinterface

// File: rtl/parking_lot_ctrl.sv
// Two-class parking occupancy controller: hour-driven capacity shifting with
// overflow migration of reserved cars into the public area.
module parking_lot_ctrl #(
  parameter int UNI_CAP     = 500,
  parameter int PUB_CAP     = 200,
  parameter int PHASE       = 50,
  parameter int SHIFT_START = 13,
  parameter int SHIFT_STEPS = 3,
  parameter int OPEN_HOUR   = 8,
  parameter int W           = 10
) (
  input  logic               clk,
  input  logic               rst,
  parking_lot_ctrl_if.slave  pif
);

  typedef enum logic {S_IDLE = 1'b0, S_REBAL = 1'b1} state_t;

  localparam logic [W-1:0] TOTAL_W   = W'(UNI_CAP + PUB_CAP);
  localparam logic [W-1:0] UNI_CAP_W = W'(UNI_CAP);
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [4:0]   OPEN_H    = 5'(OPEN_HOUR);
  localparam logic [4:0]   DAY_END   = 5'd24;

  state_t       state_q;
  logic [4:0]   hour_q;
  logic [W-1:0] uni_cap_q, uni_q, pub_q, mig_q;
  logic         ok_q, to_pub_q, deny_q, err_q;

  logic         ready, ent_fire, ext_fire;
  logic [W-1:0] u1, p1, m1, u2, p2, m2;
  logic [W-1:0] uf1, pf1, pub_cap, new_cap;
  logic         x_err, e_ok, e_tp, e_dn;

  function automatic logic [W-1:0] cap_of(input logic [4:0] h);
    int hi;
    int c;
    hi = int'(h);
    if (hi < SHIFT_START)                    c = UNI_CAP;
    else if (hi < SHIFT_START + SHIFT_STEPS) c = UNI_CAP - (hi - SHIFT_START + 1) * PHASE;
    else                                     c = UNI_CAP - SHIFT_STEPS * PHASE;
    return W'(c);
  endfunction

  // Handshake: a request is taken on the rising edge where valid && ready;
  // ready drops whenever the hour input disagrees with the registered hour,
  // so a held request simply waits out the rebalance.
  assign ready    = (state_q == S_IDLE) && (pif.hour == hour_q);
  assign ent_fire = pif.ent_valid && ready;
  assign ext_fire = pif.ext_valid && ready;
  assign pub_cap  = TOTAL_W - uni_cap_q;
  assign new_cap  = cap_of(pif.hour);

  always_comb begin
    u1    = uni_q;
    p1    = pub_q;
    m1    = mig_q;
    x_err = 1'b0;
    if (ext_fire) begin
      if (pif.ext_uni) begin
        if (uni_q != '0) begin
          u1 = uni_q - ONE;
        end else if (mig_q != '0) begin
          p1 = pub_q - ONE;
          m1 = mig_q - ONE;
        end else begin
          x_err = 1'b1;
        end
      end else if (pub_q > mig_q) begin
        p1 = pub_q - ONE;
      end else begin
        x_err = 1'b1;
      end
    end
  end

  // Entry is judged against the post-exit counts so a same-cycle exit frees a space.
  always_comb begin
    u2   = u1;
    p2   = p1;
    m2   = m1;
    e_ok = 1'b0;
    e_tp = 1'b0;
    e_dn = 1'b0;
    uf1  = (uni_cap_q > u1) ? (uni_cap_q - u1) : '0;
    pf1  = (pub_cap > p1) ? (pub_cap - p1) : '0;
    if (ent_fire) begin
      if (hour_q < OPEN_H || hour_q >= DAY_END) begin
        e_dn = 1'b1;
      end else if (pif.ent_uni) begin
        if (uf1 != '0) begin
          u2   = u1 + ONE;
          e_ok = 1'b1;
        end else if (pf1 != '0) begin
          p2   = p1 + ONE;
          m2   = m1 + ONE;
          e_ok = 1'b1;
          e_tp = 1'b1;
        end else begin
          e_dn = 1'b1;
        end
      end else if (pf1 != '0) begin
        p2   = p1 + ONE;
        e_ok = 1'b1;
      end else begin
        e_dn = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hour_q    <= '0;
      uni_cap_q <= UNI_CAP_W;
      uni_q     <= '0;
      pub_q     <= '0;
      mig_q     <= '0;
      ok_q      <= 1'b0;
      to_pub_q  <= 1'b0;
      deny_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ok_q     <= 1'b0;
      to_pub_q <= 1'b0;
      deny_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pif.hour != hour_q) begin
            state_q <= S_REBAL;
          end else begin
            uni_q    <= u2;
            pub_q    <= p2;
            mig_q    <= m2;
            ok_q     <= e_ok;
            to_pub_q <= e_tp;
            deny_q   <= e_dn;
            err_q    <= x_err;
          end
        end
        S_REBAL: begin
          hour_q    <= pif.hour;
          uni_cap_q <= new_cap;
          // Shrinking reserved area pushes its excess into the public area;
          // growth never pulls cars back.
          if (uni_q > new_cap) begin
            uni_q <= new_cap;
            pub_q <= pub_q + (uni_q - new_cap);
            mig_q <= mig_q + (uni_q - new_cap);
          end
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pif.ent_ready  = ready;
  assign pif.ext_ready  = ready;
  assign pif.uni_cnt    = uni_q;
  assign pif.pub_cnt    = pub_q;
  assign pif.mig_cnt    = mig_q;
  assign pif.uni_free   = (uni_cap_q > uni_q) ? (uni_cap_q - uni_q) : '0;
  assign pif.pub_free   = (pub_cap > pub_q) ? (pub_cap - pub_q) : '0;
  assign pif.uni_avail  = (pif.uni_free != '0);
  assign pif.pub_avail  = (pif.pub_free != '0);
  assign pif.ent_ok     = ok_q;
  assign pif.ent_to_pub = to_pub_q;
  assign pif.ent_deny   = deny_q;
  assign pif.ext_err    = err_q;
  assign pif.busy       = (state_q == S_REBAL);
  assign pif.dbg_state  = state_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Bench for parking_lot_ctrl: table-driven vectors, scoreboard-checked
// request sequences and hand-written shift/migration corner cases.
module tb_parking_lot_ctrl;
  localparam int W  = 10;
  localparam int EW = 4 + 3 * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_lot_ctrl_if #(.W(W)) pif ();

  parking_lot_ctrl #(
    .UNI_CAP(500), .PUB_CAP(200), .PHASE(50), .SHIFT_START(13),
    .SHIFT_STEPS(3), .OPEN_HOUR(8), .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif)
  );

  typedef struct {
    int hour;
    bit ev, eu, xv, xu;
    bit ok, tp, dn, er;
    int u, p, m;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  int m_uni, m_pub, m_mig, m_hour;
  vec_t tab[14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reserved capacity per hour for the default parameter set.
  function automatic int m_cap(input int h);
    if (h < 13)  return 500;
    if (h == 13) return 450;
    if (h == 14) return 400;
    return 350;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_req(input bit ev, input bit eu, input bit xv, input bit xu,
                           output logic [EW-1:0] e);
    bit ok, tp, dn, er;
    int uf, pf;
    ok = 0; tp = 0; dn = 0; er = 0;
    if (xv) begin
      if (xu) begin
        if (m_uni > 0) m_uni--;
        else if (m_mig > 0) begin m_pub--; m_mig--; end
        else er = 1;
      end else begin
        if (m_pub - m_mig > 0) m_pub--;
        else er = 1;
      end
    end
    if (ev) begin
      uf = m_cap(m_hour) - m_uni;
      pf = 700 - m_cap(m_hour) - m_pub;
      if (pf < 0) pf = 0;
      if (m_hour < 8 || m_hour >= 24) dn = 1;
      else if (eu) begin
        if (uf > 0) begin m_uni++; ok = 1; end
        else if (pf > 0) begin m_pub++; m_mig++; ok = 1; tp = 1; end
        else dn = 1;
      end else begin
        if (pf > 0) begin m_pub++; ok = 1; end
        else dn = 1;
      end
    end
    e = {ok, tp, dn, er, W'(m_uni), W'(m_pub), W'(m_mig)};
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!pif.ent_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!pif.ent_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got ready=0 want ready=1 within 20 cycles");
    end
  endtask

  // One request cycle; expectation comes from the table row or the model.
  task automatic do_req(input bit ev, input bit eu, input bit xv, input bit xu,
                        input bit use_tab, input logic [EW-1:0] tab_exp);
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    @(negedge clk);
    wait_ready();
    pif.ent_valid = ev;
    pif.ent_uni   = eu;
    pif.ext_valid = xv;
    pif.ext_uni   = xu;
    model_req(ev, eu, xv, xu, e);
    exp_q.push_back(use_tab ? tab_exp : e);
    @(posedge clk);
    #1;
    pif.ent_valid = 1'b0;
    pif.ext_valid = 1'b0;
    got  = {pif.ent_ok, pif.ent_to_pub, pif.ent_deny, pif.ext_err,
            pif.uni_cnt, pif.pub_cnt, pif.mig_cnt};
    want = exp_q.pop_front();
    check("event_verdict", 64'(got), 64'(want));
  endtask

  task automatic set_hour(input int h);
    int busy_n;
    int c, ex, uf, pf;
    @(negedge clk);
    pif.hour = 5'(h);
    #1;
    check("stall_ready", 64'(pif.ent_ready), 64'(0));
    busy_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pif.busy) busy_n++;
    end
    check("busy_cycles", 64'(busy_n), 64'(1));
    check("ready_after_rebal", 64'(pif.ext_ready), 64'(1));
    m_hour = h;
    c = m_cap(h);
    if (m_uni > c) begin
      ex = m_uni - c;
      m_uni = c;
      m_pub += ex;
      m_mig += ex;
    end
    uf = c - m_uni;
    pf = 700 - c - m_pub;
    if (pf < 0) pf = 0;
    check("rebal_state",
          64'({pif.uni_cnt, pif.pub_cnt, pif.mig_cnt, pif.uni_free, pif.pub_free}),
          64'({W'(m_uni), W'(m_pub), W'(m_mig), W'(uf), W'(pf)}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pif.hour = '0;
    pif.ent_valid = 1'b0; pif.ent_uni = 1'b0;
    pif.ext_valid = 1'b0; pif.ext_uni = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state",
          64'({pif.ent_ok, pif.ent_to_pub, pif.ent_deny, pif.ext_err, pif.busy,
               pif.uni_avail, pif.pub_avail, pif.uni_cnt, pif.pub_cnt, pif.mig_cnt,
               pif.uni_free, pif.pub_free}),
          64'({4'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 10'd0, 10'd500, 10'd200}));
    rst = 1'b0;
    m_uni = 0; m_pub = 0; m_mig = 0; m_hour = 0;
  endtask

  initial begin
    logic [EW-1:0] te;
    tab[0]  = '{9,  1,1,0,0, 1,0,0,0, 1,0,0};
    tab[1]  = '{9,  1,1,0,0, 1,0,0,0, 2,0,0};
    tab[2]  = '{9,  1,1,0,0, 1,0,0,0, 3,0,0};
    tab[3]  = '{9,  1,0,0,0, 1,0,0,0, 3,1,0};
    tab[4]  = '{9,  0,0,1,0, 0,0,0,0, 3,0,0};
    tab[5]  = '{9,  0,0,1,0, 0,0,0,1, 3,0,0};
    tab[6]  = '{9,  0,0,1,1, 0,0,0,0, 2,0,0};
    tab[7]  = '{9,  1,1,1,1, 1,0,0,0, 2,0,0};
    tab[8]  = '{7,  1,0,0,0, 0,0,1,0, 2,0,0};
    tab[9]  = '{7,  0,0,1,1, 0,0,0,0, 1,0,0};
    tab[10] = '{7,  0,0,1,1, 0,0,0,0, 0,0,0};
    tab[11] = '{7,  0,0,1,1, 0,0,0,1, 0,0,0};
    tab[12] = '{7,  1,1,1,1, 0,0,1,1, 0,0,0};
    tab[13] = '{25, 1,1,0,0, 0,0,1,0, 0,0,0};

    rst = 1'b1;
    pif.hour = '0;
    pif.ent_valid = 1'b0; pif.ent_uni = 1'b0;
    pif.ext_valid = 1'b0; pif.ext_uni = 1'b0;

    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (tab[i].hour != m_hour) set_hour(tab[i].hour);
      te = {tab[i].ok, tab[i].tp, tab[i].dn, tab[i].er,
            W'(tab[i].u), W'(tab[i].p), W'(tab[i].m)};
      do_req(tab[i].ev, tab[i].eu, tab[i].xv, tab[i].xu, 1'b1, te);
      m_uni = tab[i].u; m_pub = tab[i].p; m_mig = tab[i].m;
    end

    // Reserved overflow into the public area.
    do_reset();
    set_hour(9);
    for (int i = 0; i < 500; i++) do_req(1, 1, 0, 0, 1'b0, '0);
    check("uni_avail_full", 64'(pif.uni_avail), 64'(0));
    do_req(1, 1, 0, 0, 1'b0, '0);
    check("overflow_pulses", 64'({pif.ent_ok, pif.ent_to_pub}), 64'(2'b11));
    check("overflow_counts", 64'({pif.uni_cnt, pif.pub_cnt, pif.mig_cnt}),
          64'({10'd500, 10'd1, 10'd1}));

    // Afternoon capacity shifting with migration.
    do_reset();
    set_hour(9);
    for (int i = 0; i < 500; i++) do_req(1, 1, 0, 0, 1'b0, '0);
    set_hour(12);
    set_hour(13);
    check("h13_counts", 64'({pif.uni_cnt, pif.pub_cnt, pif.mig_cnt, pif.pub_free}),
          64'({10'd450, 10'd50, 10'd50, 10'd200}));
    set_hour(14);
    check("h14_counts", 64'({pif.uni_cnt, pif.pub_cnt, pif.mig_cnt}),
          64'({10'd400, 10'd100, 10'd100}));
    set_hour(16);
    check("h16_counts", 64'({pif.uni_cnt, pif.pub_cnt, pif.mig_cnt}),
          64'({10'd350, 10'd150, 10'd150}));
    for (int i = 0; i < 498; i++) do_req(0, 0, 1, 1, 1'b0, '0);
    check("drained_counts", 64'({pif.uni_cnt, pif.pub_cnt, pif.mig_cnt}),
          64'({10'd0, 10'd2, 10'd2}));
    do_req(0, 0, 1, 1, 1'b0, '0);
    check("mig_exit", 64'({pif.ext_err, pif.pub_cnt, pif.mig_cnt}),
          64'({1'b0, 10'd1, 10'd1}));
    do_req(0, 0, 1, 0, 1'b0, '0);
    check("pub_exit_err", 64'({pif.ext_err, pif.pub_cnt}), 64'({1'b1, 10'd1}));

    // Entry held across an hour change is taken exactly once.
    @(negedge clk);
    pif.hour = 5'd17;
    pif.ent_valid = 1'b1;
    pif.ent_uni = 1'b0;
    #1;
    check("held_stall", 64'(pif.ent_ready), 64'(0));
    @(negedge clk);
    wait_ready();
    m_hour = 17;
    model_req(1, 0, 0, 0, te);
    @(posedge clk);
    #1;
    pif.ent_valid = 1'b0;
    check("held_entry", 64'({pif.ent_ok, pif.pub_cnt}), 64'({1'b1, W'(m_pub)}));
    @(posedge clk);
    #1;
    check("held_once", 64'({pif.ent_ok, pif.pub_cnt}), 64'({1'b0, W'(m_pub)}));

    // Full public area: simultaneous exit and entry.
    do_reset();
    set_hour(9);
    for (int i = 0; i < 200; i++) do_req(1, 0, 0, 0, 1'b0, '0);
    check("pub_full", 64'({pif.pub_free, pif.pub_avail}), 64'({10'd0, 1'b0}));
    do_req(1, 0, 0, 0, 1'b0, '0);
    check("pub_full_deny", 64'(pif.ent_deny), 64'(1));
    do_req(1, 0, 1, 0, 1'b0, '0);
    check("swap_in_out", 64'({pif.ent_ok, pif.ext_err, pif.pub_cnt}),
          64'({1'b1, 1'b0, 10'd200}));

    // Asynchronous reset mid-cycle clears at once.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 64'({pif.uni_cnt, pif.pub_cnt, pif.mig_cnt, pif.busy}),
          64'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
